// File: rtl/top.sv
// Single-cycle MIPS32 subset core: add/sub/and/or/slt, lw, sw, beq, addi, j.
// Ports: clk (rising-edge clock), rst_n (asynchronous active-low reset).
// All architectural state is reached hierarchically:
//   reg_file.reg_file[0:31], inst_memory.inst_mem[], data_mem.mem[].

module imem #(
  parameter int DEPTH = 256
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] inst_mem [0:DEPTH-1] = '{default: '0};
  logic [31:0] word_idx;
  logic        unused_addr;

  assign word_idx    = {2'b00, addr[31:2]} % 32'(DEPTH);
  assign instr       = inst_mem[word_idx[AW-1:0]];
  assign unused_addr = ^{addr[1:0], word_idx[31:AW]};
endmodule

module dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [0:DEPTH-1] = '{default: '0};
  logic [31:0] word_idx;
  logic        unused_addr;

  assign word_idx    = {2'b00, addr[31:2]} % 32'(DEPTH);
  assign rd          = mem[word_idx[AW-1:0]];
  assign unused_addr = ^{addr[1:0], word_idx[31:AW]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[word_idx[AW-1:0]] <= wd;
    end
  end
endmodule

module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        reg_file[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      reg_file[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : reg_file[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : reg_file[ra2];
endmodule

module top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst_n
);
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_t;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] imm_sext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        mem_we;
  logic        dmem_we;
  logic [4:0]  unused_shamt;
  opcode_t     opcode;
  funct_t      funct;

  assign opcode       = opcode_t'(instr[31:26]);
  assign funct        = funct_t'(instr[5:0]);
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = instr[10:6];
  assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4     = pc + 32'd4;
  assign mem_addr     = rs_val + imm_sext;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rt;
    wb_data = '0;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        wb_addr = rd;
        case (funct)
          FN_ADD: begin wb_en = 1'b1; wb_data = rs_val + rt_val; end
          FN_SUB: begin wb_en = 1'b1; wb_data = rs_val - rt_val; end
          FN_AND: begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
          FN_OR:  begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
          FN_SLT: begin
            wb_en   = 1'b1;
            wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          end
          default: ;
        endcase
      end
      OP_LW: begin
        wb_en   = 1'b1;
        wb_data = mem_rdata;
      end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ: begin
        if (rs_val == rt_val) begin
          pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
        end
      end
      OP_ADDI: begin
        wb_en   = 1'b1;
        wb_data = rs_val + imm_sext;
      end
      OP_J:    pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  // Memory has no reset branch; the store is masked here so that an
  // instruction seen while reset is held never reaches the array.
  assign dmem_we = mem_we & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  imem #(.DEPTH(IMEM_DEPTH)) inst_memory (
    .addr  (pc),
    .instr (instr)
  );

  regfile reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  dmem #(.DEPTH(DMEM_DEPTH)) data_mem (
    .clk  (clk),
    .we   (dmem_we),
    .addr (mem_addr),
    .wd   (rt_val),
    .rd   (mem_rdata)
  );
endmodule

// File: tb/tb_top.sv
module tb_top;
  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;

  localparam int ZERO = 0;
  localparam int T0 = 8,  T1 = 9,  T2 = 10, T3 = 11, T4 = 12, T5 = 13;
  localparam int T6 = 14, T7 = 15, T8 = 24, T9 = 25;
  localparam int S1 = 17, S2 = 18, S3 = 19, S4 = 20, S5 = 21;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef struct {
    int          edge_n;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                        input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input int target);
    return {op, 26'(target)};
  endfunction

  function automatic logic [31:0] get_actual(input int kind, input int idx);
    case (kind)
      K_REG:   return dut.reg_file.reg_file[idx];
      K_MEM:   return dut.data_mem.mem[idx];
      default: return dut.pc;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input int e, input int k, input int i, input logic [31:0] x,
                     input string n);
    vec_t v;
    v = '{e, k, i, x, n};
    vecs.push_back(v);
  endtask

  task automatic run_table(input int n_edges);
    vec_t v;
    for (int e = 1; e <= n_edges; e++) begin
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == e) sb.push_back(vecs[i]);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        v = sb.pop_front();
        check(v.name, get_actual(v.kind, v.idx), v.exp);
      end
    end
  endtask

  task automatic preload_regs();
    dut.reg_file.reg_file[S1] = 32'd5;
    dut.reg_file.reg_file[S2] = 32'd8;
    dut.reg_file.reg_file[S3] = 32'd4;
    dut.reg_file.reg_file[S4] = 32'd2;
    dut.reg_file.reg_file[S5] = 32'd2;
    dut.reg_file.reg_file[T1] = 32'd14;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_t0", dut.reg_file.reg_file[T0], 32'd0);
    check("dmem_zero_init_10", dut.data_mem.mem[10], 32'd0);
    check("imem_zero_init_100", dut.inst_memory.inst_mem[100], 32'd0);

    // Program 1
    dut.inst_memory.inst_mem[0] = rtype(S1, S2, T0, FN_ADD);
    dut.inst_memory.inst_mem[1] = itype(OP_LW, S3, T0, 4);
    dut.inst_memory.inst_mem[2] = itype(OP_SW, S2, T1, 0);
    dut.inst_memory.inst_mem[3] = itype(OP_BEQ, S4, S5, 1);
    dut.inst_memory.inst_mem[4] = rtype(S1, S2, T0, FN_ADD);
    dut.inst_memory.inst_mem[5] = rtype(S4, S3, T0, FN_SUB);

    add(1, K_REG, T0, 32'd13,        "p1_add_t0");
    add(1, K_PC,  0,  32'd4,         "p1_pc1");
    add(2, K_REG, T0, 32'd20,        "p1_lw_t0");
    add(2, K_PC,  0,  32'd8,         "p1_pc2");
    add(3, K_MEM, 2,  32'd14,        "p1_sw_mem2");
    add(3, K_MEM, 1,  32'd15,        "p1_mem1_kept");
    add(4, K_PC,  0,  32'd20,        "p1_beq_taken_pc");
    add(4, K_REG, T0, 32'd20,        "p1_t0_after_beq");
    add(5, K_REG, T0, 32'hFFFFFFFE,  "p1_sub_t0");
    add(5, K_PC,  0,  32'd24,        "p1_pc5");
    add(6, K_REG, T0, 32'hFFFFFFFE,  "p1_nop6_t0");
    add(6, K_PC,  0,  32'd28,        "p1_nop6_pc");
    add(7, K_REG, T0, 32'hFFFFFFFE,  "p1_nop7_t0");

    @(negedge clk);
    rst_n = 1'b1;
    preload_regs();
    dut.data_mem.mem[0] = 32'd11;
    dut.data_mem.mem[1] = 32'd15;
    dut.data_mem.mem[2] = 32'd20;
    dut.data_mem.mem[3] = 32'd40;
    dut.data_mem.mem[4] = 32'd30;
    dut.data_mem.mem[5] = 32'd50;
    check("release_pc", dut.pc, 32'd0);
    run_table(7);

    // Reset between programs: asynchronous clear, memories kept
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst1_pc_async", dut.pc, 32'd0);
    check("rst1_t0_async", dut.reg_file.reg_file[T0], 32'd0);
    check("rst1_mem2_kept", dut.data_mem.mem[2], 32'd14);
    check("rst1_imem5_kept", dut.inst_memory.inst_mem[5], rtype(S4, S3, T0, FN_SUB));

    // Program 2: wrap, slt, logic ops, $zero, address wrap, beq not taken, j, NOPs
    dut.inst_memory.inst_mem[0]  = itype(OP_ADDI, ZERO, T2, -1);
    dut.inst_memory.inst_mem[1]  = rtype(T2, S1, T3, FN_ADD);
    dut.inst_memory.inst_mem[2]  = rtype(T2, S1, T4, FN_SLT);
    dut.inst_memory.inst_mem[3]  = rtype(S1, T2, T5, FN_SLT);
    dut.inst_memory.inst_mem[4]  = rtype(S1, S3, T6, FN_AND);
    dut.inst_memory.inst_mem[5]  = rtype(S1, S2, T7, FN_OR);
    dut.inst_memory.inst_mem[6]  = rtype(S1, S2, ZERO, FN_ADD);
    dut.inst_memory.inst_mem[7]  = itype(OP_SW, ZERO, S2, 1025);
    dut.inst_memory.inst_mem[8]  = itype(OP_LW, ZERO, T8, 3);
    dut.inst_memory.inst_mem[9]  = itype(OP_BEQ, S4, S3, 5);
    dut.inst_memory.inst_mem[10] = jtype(OP_J, 12);
    dut.inst_memory.inst_mem[11] = itype(OP_ADDI, ZERO, T9, 99);
    dut.inst_memory.inst_mem[12] = itype(OP_ADDI, ZERO, T9, 7);
    dut.inst_memory.inst_mem[13] = rtype(S1, S2, T9, 6'h21);
    dut.inst_memory.inst_mem[14] = itype(6'h3F, ZERO, T9, 123);
    dut.inst_memory.inst_mem[15] = itype(OP_BEQ, ZERO, ZERO, -1);

    vecs.delete();
    add(1,  K_REG, T2, 32'hFFFFFFFF, "p2_addi_neg");
    add(1,  K_PC,  0,  32'd4,        "p2_pc1");
    add(2,  K_REG, T3, 32'd4,        "p2_add_wrap");
    add(3,  K_REG, T4, 32'd1,        "p2_slt_signed_true");
    add(4,  K_REG, T5, 32'd0,        "p2_slt_signed_false");
    add(5,  K_REG, T6, 32'd4,        "p2_and");
    add(6,  K_REG, T7, 32'd13,       "p2_or");
    add(7,  K_REG, ZERO, 32'd0,      "p2_zero_write_dropped");
    add(7,  K_PC,  0,  32'd28,       "p2_pc7");
    add(8,  K_MEM, 0,  32'd8,        "p2_sw_addr_wrap");
    add(9,  K_REG, T8, 32'd8,        "p2_lw_low_bits_ignored");
    add(10, K_PC,  0,  32'd40,       "p2_beq_not_taken");
    add(11, K_PC,  0,  32'd48,       "p2_jump");
    add(12, K_REG, T9, 32'd7,        "p2_addi_after_jump");
    add(12, K_PC,  0,  32'd52,       "p2_pc12");
    add(13, K_REG, T9, 32'd7,        "p2_bad_funct_nop");
    add(13, K_PC,  0,  32'd56,       "p2_pc13");
    add(14, K_REG, T9, 32'd7,        "p2_bad_opcode_nop");
    add(14, K_PC,  0,  32'd60,       "p2_pc14");
    add(15, K_PC,  0,  32'd60,       "p2_beq_self_loop");
    add(16, K_PC,  0,  32'd60,       "p2_beq_self_loop2");

    @(negedge clk);
    rst_n = 1'b1;
    preload_regs();
    run_table(16);

    // Mid-run reset: async clear, a store seen during reset is suppressed
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_pc_async", dut.pc, 32'd0);
    check("rst2_t9_async", dut.reg_file.reg_file[T9], 32'd0);
    check("rst2_t2_async", dut.reg_file.reg_file[T2], 32'd0);
    check("rst2_zero", dut.reg_file.reg_file[ZERO], 32'd0);
    dut.inst_memory.inst_mem[0] = itype(OP_SW, ZERO, ZERO, 8);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_store_suppressed", dut.data_mem.mem[2], 32'd14);
    check("rst2_mem0_kept", dut.data_mem.mem[0], 32'd8);
    check("rst2_pc_held", dut.pc, 32'd0);
    check("rst2_imem15_kept", dut.inst_memory.inst_mem[15], itype(OP_BEQ, ZERO, ZERO, -1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: number of 32-bit words in instruction memory.
REQ-002 Parameter DMEM_DEPTH, default 256: number of 32-bit words in data memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 No other ports; all state is observed and preloaded hierarchically.
REQ-006 Hierarchy names fixed:
- register file instance reg_file, array reg_file[0:31], 32 bits each;
- instruction memory instance inst_memory, array inst_mem[0:IMEM_DEPTH-1];
- data memory instance data_mem, array mem[0:DMEM_DEPTH-1].

Function
REQ-007 Single-cycle MIPS32 core: one instruction fetched, executed and retired per rising clk edge.
REQ-008 PC is 32 bits; instruction = inst_mem[PC[31:2]], combinational read.
REQ-009 Next PC is PC+4, except for taken beq and j.
REQ-010 R-type (opcode 000000) uses rs/rt sources and rd destination, by funct:
- add 100000 and sub 100010: wrap-around 32-bit two's complement, no overflow trap;
- and 100100, or 100101;
- slt 101010: signed compare, result 1 or 0.
REQ-011 R-type with any other funct (including 0x00000000) SHALL be a NOP: no register write, PC+4.
REQ-012 lw (100011): rt <= mem[(rs + sext(imm16))[31:2]].
REQ-013 sw (101011): mem[(rs + sext(imm16))[31:2]] <= rt, written at the rising edge.
REQ-014 Address bits [1:0] are ignored (byte address, word-aligned access).
REQ-015 beq (000100): if rs == rt, PC <= PC + 4 + (sext(imm16) << 2); otherwise PC+4.
REQ-016 addi (001000): rt <= rs + sext(imm16), wrap-around.
REQ-017 j (000010): PC <= {PC_plus4[31:28], imm26, 2'b00}.
REQ-018 Unrecognised opcodes SHALL be NOPs.
REQ-019 Register file:
- two combinational read ports, one write port written at the rising edge;
- register 0 always reads 0 and writes to it are discarded.
REQ-020 Data memory: combinational read, synchronous write. The read value seen by an instruction is the pre-edge contents.
REQ-021 Memory indices beyond the array depth wrap modulo the depth (low address bits only).
REQ-022 All results written by an instruction are visible to the next instruction (no hazards, no stalls).
REQ-023 Both memories SHALL be zero-initialised at time 0 and SHALL remain writable hierarchically by the bench at any time.

Reset
REQ-024 While rst_n = 0: PC = 0 and all 32 registers = 0, asynchronously; no memory write occurs.
REQ-025 Reset SHALL NOT clear the instruction or data memory.
REQ-026 On reset deassertion, the first rising edge executes inst_mem[0].
REQ-027 Reset asserted mid-program aborts the current instruction; its register or memory write is suppressed.

Verification
Common preload, after rst_n rises: $s1=5, $s2=8, $s3=4, $s4=2, $s5=2, $t1=14; mem[0..5] = 11, 15, 20, 40, 30, 50.
Program at inst_mem[0..5]: add $t0,$s1,$s2; lw $t0,4($s3); sw $t1,0($s2); beq $s4,$s5,1; add $t0,$s1,$s2; sub $t0,$s4,$s3.
REQ-028 Edge 1 (add) -> $t0 = 13.
REQ-029 Edge 2 (lw, address 8) -> $t0 = 20.
REQ-030 Edge 3 (sw, address 8) -> mem[2] = 14.
REQ-031 Edge 4 (beq taken) -> PC = 20; inst_mem[4] is skipped.
REQ-032 Edge 5 (sub) -> $t0 = 0xFFFFFFFE (-2); $t0 SHALL remain -2 through the subsequent zero (NOP) instructions.
REQ-033 Writing $zero with add, then asserting rst_n low mid-run -> $zero reads 0; PC and registers read 0 immediately, without waiting for a clock edge; memories retain their contents.
